// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak-f round controller.
package keccak_pkg;

  localparam int NUM_ROUNDS_DEFAULT = 24;
  localparam int MAX_PERM_DEFAULT   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUND   = 2'd1,
    WAIT_DP = 2'd2,
    FINISH  = 2'd3
  } state_e;

  // Clock steps needed for one permutation (R).
  function automatic int steps_per_perm(input int num_rounds, input int rounds_per_cycle);
    return num_rounds / rounds_per_cycle;
  endfunction

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Bus between the register file / Keccak datapath and the round controller.
// cyc_cnt_o only exists when KECCAK_ROUND_CTRL_PERF_EN is defined.
interface keccak_round_ctrl_if
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int MAX_PERM   = MAX_PERM_DEFAULT
) ();

  localparam int RW = $clog2(NUM_ROUNDS);
  localparam int PW = $clog2(MAX_PERM);
  localparam int NW = $clog2(MAX_PERM + 1);

  // Handshake: a launch happens only in a cycle where start_i (IDLE) or the
  // pending next permutation (WAIT_DP) meets ready_dp_i high with abort_i low;
  // start_dp_o marks exactly those cycles. A start_i seen without ready_dp_i
  // is dropped, never queued.
  logic          start_i;
  logic [NW-1:0] nperm_i;
  logic          abort_i;
  logic          ready_dp_i;
  logic          intr_clr_i;
  logic          start_dp_o;
  logic          round_en_o;
  logic [RW-1:0] round_idx_o;
  logic [PW-1:0] perm_idx_o;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;
  logic          intr_o;
  state_e        dbg_state_o;
`ifdef KECCAK_ROUND_CTRL_PERF_EN
  logic [31:0]   cyc_cnt_o;
`endif

  modport master (
    output start_i, nperm_i, abort_i, ready_dp_i, intr_clr_i,
    input  start_dp_o, round_en_o, round_idx_o, perm_idx_o, busy_o,
           done_o, aborted_o, intr_o, dbg_state_o
`ifdef KECCAK_ROUND_CTRL_PERF_EN
    , input cyc_cnt_o
`endif
  );

  modport slave (
    input  start_i, nperm_i, abort_i, ready_dp_i, intr_clr_i,
    output start_dp_o, round_en_o, round_idx_o, perm_idx_o, busy_o,
           done_o, aborted_o, intr_o, dbg_state_o
`ifdef KECCAK_ROUND_CTRL_PERF_EN
    , output cyc_cnt_o
`endif
  );

endinterface

// File: rtl/keccak_round_cnt.sv
// Round counter: advances by ROUNDS_PER_CYCLE per step and flags the last
// step of a permutation, after which it returns to 0 by itself.
module keccak_round_cnt
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS       = NUM_ROUNDS_DEFAULT,
  parameter int ROUNDS_PER_CYCLE = 1,
  localparam int RW              = $clog2(NUM_ROUNDS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          step_i,
  input  logic          clr_i,
  output logic [RW-1:0] cnt_o,
  output logic          last_o
);

  localparam int LAST_STEP =
    (steps_per_perm(NUM_ROUNDS, ROUNDS_PER_CYCLE) - 1) * ROUNDS_PER_CYCLE;
  localparam logic [RW-1:0] LAST_CNT = RW'(LAST_STEP);
  localparam logic [RW-1:0] INC      = RW'(ROUNDS_PER_CYCLE);

  logic [RW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LAST_CNT);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = last_o ? '0 : cnt_q + INC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keccak_round_ctrl.sv
// Keccak-f round/batch sequencer with abort and sticky interrupt.
// Define KECCAK_ROUND_CTRL_PERF_EN to add the busy-cycle counter cyc_cnt_o.
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS       = NUM_ROUNDS_DEFAULT,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int MAX_PERM         = MAX_PERM_DEFAULT
) (
  input logic                clk_i,
  input logic                rst_ni,
  keccak_round_ctrl_if.slave bus
);

  localparam int RW = $clog2(NUM_ROUNDS);
  localparam int PW = $clog2(MAX_PERM);
  localparam int NW = $clog2(MAX_PERM + 1);

  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > NUM_ROUNDS ||
      (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
    $error("keccak_round_ctrl: ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] perm_cnt_q, perm_cnt_d;
  logic [PW-1:0] perm_last_q, perm_last_d;
  logic          intr_q, intr_d;

  logic          rnd_step, rnd_clr, rnd_last;
  logic [RW-1:0] rnd_cnt;
  logic          start_dp, round_en, done, intr_set, abort_take;
  logic [NW-1:0] nperm_m1;

  keccak_round_cnt #(
    .NUM_ROUNDS      (NUM_ROUNDS),
    .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
  ) u_round_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .step_i(rnd_step),
    .clr_i (rnd_clr),
    .cnt_o (rnd_cnt),
    .last_o(rnd_last)
  );

  always_comb begin
    state_d     = state_q;
    perm_cnt_d  = perm_cnt_q;
    perm_last_d = perm_last_q;
    rnd_step    = 1'b0;
    rnd_clr     = 1'b0;
    start_dp    = 1'b0;
    round_en    = 1'b0;
    done        = 1'b0;
    intr_set    = 1'b0;
    nperm_m1    = bus.nperm_i - NW'(1);
    abort_take  = (state_q != IDLE) && bus.abort_i;

    case (state_q)
      IDLE: begin
        perm_cnt_d = '0;
        if (bus.start_i && bus.ready_dp_i && !bus.abort_i) begin
          start_dp = 1'b1;
          rnd_clr  = 1'b1;
          state_d  = ROUND;
          // Batch size is kept as "index of last permutation", already clamped.
          if (bus.nperm_i == '0) begin
            perm_last_d = '0;
          end else if (bus.nperm_i > NW'(MAX_PERM)) begin
            perm_last_d = PW'(MAX_PERM - 1);
          end else begin
            perm_last_d = PW'(nperm_m1);
          end
        end
      end
      ROUND: begin
        round_en = 1'b1;
        rnd_step = 1'b1;
        if (rnd_last) begin
          if (perm_cnt_q == perm_last_q) begin
            state_d = FINISH;
          end else begin
            perm_cnt_d = perm_cnt_q + PW'(1);
            state_d    = WAIT_DP;
          end
        end
      end
      WAIT_DP: begin
        if (bus.ready_dp_i) begin
          start_dp = 1'b1;
          state_d  = ROUND;
        end
      end
      FINISH: begin
        done       = 1'b1;
        intr_set   = 1'b1;
        perm_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including the last round and FINISH.
    if (abort_take) begin
      state_d    = IDLE;
      perm_cnt_d = '0;
      rnd_clr    = 1'b1;
      rnd_step   = 1'b0;
      start_dp   = 1'b0;
      done       = 1'b0;
      intr_set   = 1'b0;
    end

    intr_d = intr_q;
    if (bus.intr_clr_i) intr_d = 1'b0;
    if (intr_set)       intr_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      perm_cnt_q  <= '0;
      perm_last_q <= '0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      perm_cnt_q  <= perm_cnt_d;
      perm_last_q <= perm_last_d;
      intr_q      <= intr_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign bus.start_dp_o  = rst_ni && start_dp;
  assign bus.round_en_o  = rst_ni && round_en;
  assign bus.round_idx_o = (rst_ni && state_q == ROUND) ? rnd_cnt : '0;
  assign bus.perm_idx_o  = rst_ni ? perm_cnt_q : '0;
  assign bus.busy_o      = rst_ni && (state_q != IDLE);
  assign bus.done_o      = rst_ni && done;
  assign bus.aborted_o   = rst_ni && abort_take;
  assign bus.intr_o      = rst_ni && (intr_q || intr_set);
  assign bus.dbg_state_o = state_q;

`ifdef KECCAK_ROUND_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == IDLE) begin
      if (start_dp) cyc_cnt_d = '0;
    end else if (cyc_cnt_q != '1) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign bus.cyc_cnt_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench for keccak_round_ctrl: default instance (1 round/cycle) and
// a 4-rounds/cycle instance, with an event monitor feeding queue scoreboards.
module tb_keccak_round_ctrl;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  int start_q[$], done_q[$], abort_q[$], rnd_q[$], rnd_cyc_q[$], pidx_q[$];
  int intr_rise_q[$], busy_fall_q[$];
  int start4_q[$], done4_q[$], rnd4_q[$];
  int wait_lo = 0;
  logic prev_intr = 1'b0;
  logic prev_busy = 1'b0;

  keccak_round_ctrl_if #(.NUM_ROUNDS(24), .MAX_PERM(16)) bus ();
  keccak_round_ctrl_if #(.NUM_ROUNDS(24), .MAX_PERM(16)) bus4 ();

  keccak_round_ctrl #(
    .NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(1), .MAX_PERM(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  keccak_round_ctrl #(
    .NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4), .MAX_PERM(16)
  ) dut4 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus4.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor (samples 2 time units after the falling edge) ----
  always @(negedge clk) begin
    #2;
    if (bus.start_dp_o) start_q.push_back(cyc);
    if (bus.done_o)     done_q.push_back(cyc);
    if (bus.aborted_o)  abort_q.push_back(cyc);
    if (bus.round_en_o) begin
      rnd_q.push_back(int'(bus.round_idx_o));
      rnd_cyc_q.push_back(cyc);
      if (bus.round_idx_o == '0) pidx_q.push_back(int'(bus.perm_idx_o));
    end
    if (bus.intr_o && !prev_intr)  intr_rise_q.push_back(cyc);
    if (!bus.busy_o && prev_busy)  busy_fall_q.push_back(cyc);
    if (bus.dbg_state_o == WAIT_DP && !bus.ready_dp_i && !bus.round_en_o) wait_lo++;
    prev_intr = bus.intr_o;
    prev_busy = bus.busy_o;
    if (bus4.start_dp_o) start4_q.push_back(cyc);
    if (bus4.done_o)     done4_q.push_back(cyc);
    if (bus4.round_en_o) rnd4_q.push_back(int'(bus4.round_idx_o));
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check_seq(input string tag, input int got[$]);
    check_eq({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check_eq(tag, qget(got, i), exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic prep();
    @(negedge clk);
    bus.intr_clr_i  = 1'b1;
    bus4.intr_clr_i = 1'b1;
    @(negedge clk);
    bus.intr_clr_i  = 1'b0;
    bus4.intr_clr_i = 1'b0;
    start_q.delete(); done_q.delete(); abort_q.delete(); rnd_q.delete();
    rnd_cyc_q.delete(); pidx_q.delete(); intr_rise_q.delete(); busy_fall_q.delete();
    start4_q.delete(); done4_q.delete(); rnd4_q.delete();
    wait_lo = 0;
  endtask

  task automatic start_batch(input int n, output int t);
    @(negedge clk);
    t = cyc;
    bus.nperm_i = n[4:0];
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic start_batch4(input int n, output int t);
    @(negedge clk);
    t = cyc;
    bus4.nperm_i = n[4:0];
    bus4.start_i = 1'b1;
    @(negedge clk);
    bus4.start_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, t2;
    rst_n = 1'b0;
    bus.start_i = 1'b0;  bus.nperm_i = '0;  bus.abort_i = 1'b0;
    bus.ready_dp_i = 1'b1;  bus.intr_clr_i = 1'b0;
    bus4.start_i = 1'b0; bus4.nperm_i = '0; bus4.abort_i = 1'b0;
    bus4.ready_dp_i = 1'b1; bus4.intr_clr_i = 1'b0;

    // reset
    step(3);
    #1;
    check_eq("rst_busy_in_reset", bus.busy_o, 0);
    check_eq("rst_intr_in_reset", bus.intr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_done", bus.done_o, 0);
    check_eq("rst_intr", bus.intr_o, 0);
    check_eq("rst_start_dp", bus.start_dp_o, 0);
    check_eq("rst_round_en", bus.round_en_o, 0);
    check_eq("rst_perm_idx", bus.perm_idx_o, 0);
    check_eq("rst_state", bus.dbg_state_o, IDLE);

    // single permutation, ready always high
    prep();
    start_batch(1, t);
    step(30);
    #1;
    check_eq("t1_nstart", start_q.size(), 1);
    check_eq("t1_start_cyc", qget(start_q, 0), t);
    for (int i = 0; i < 24; i++) exp_q.push_back(i);
    check_seq("t1_round_idx", rnd_q);
    check_eq("t1_first_round", qget(rnd_cyc_q, 0), t + 1);
    check_eq("t1_last_round", qget(rnd_cyc_q, 23), t + 24);
    check_eq("t1_ndone", done_q.size(), 1);
    check_eq("t1_done_cyc", qget(done_q, 0), t + 25);
    check_eq("t1_intr_rise", qget(intr_rise_q, 0), t + 25);
    check_eq("t1_busy_fall", qget(busy_fall_q, 0), t + 26);
    check_eq("t1_intr_sticky", bus.intr_o, 1);
    check_eq("t1_wait_lo", wait_lo, 0);

    // three permutations back to back
    prep();
    start_batch(3, t);
    step(80);
    exp_q.push_back(t); exp_q.push_back(t + 25); exp_q.push_back(t + 50);
    check_seq("t2_start_cyc", start_q);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    check_seq("t2_perm_idx", pidx_q);
    check_eq("t2_nrounds", rnd_q.size(), 72);
    check_eq("t2_ndone", done_q.size(), 1);
    check_eq("t2_done_cyc", qget(done_q, 0), t + 75);

    // two permutations, datapath not ready for 5 cycles in between
    prep();
    start_batch(2, t);
    bus.ready_dp_i = 1'b0;
    step(29);
    bus.ready_dp_i = 1'b1;
    step(40);
    check_eq("t3_wait_lo", wait_lo, 5);
    exp_q.push_back(t); exp_q.push_back(t + 30);
    check_seq("t3_start_cyc", start_q);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 24; i++) exp_q.push_back(i);
    check_seq("t3_round_idx", rnd_q);
    check_eq("t3_second_round0_cyc", qget(rnd_cyc_q, 24), t + 31);
    check_eq("t3_done_cyc", qget(done_q, 0), t + 55);

    // abort at round 10, then an immediate restart
    prep();
    start_batch(1, t);
    step(10);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    t2 = cyc;
    bus.nperm_i = 5'd1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    step(30);
    check_eq("t4_nabort", abort_q.size(), 1);
    check_eq("t4_abort_cyc", qget(abort_q, 0), t + 11);
    check_eq("t4_abort_round", qget(rnd_q, 10), 10);
    check_eq("t4_busy_fall", qget(busy_fall_q, 0), t + 12);
    check_eq("t4_restart_cyc", t2, t + 12);
    check_eq("t4_restart_start", qget(start_q, 1), t + 12);
    check_eq("t4_restart_round0", qget(rnd_q, 11), 0);
    check_eq("t4_restart_round0_cyc", qget(rnd_cyc_q, 11), t + 13);
    check_eq("t4_nrounds", rnd_q.size(), 35);
    check_eq("t4_ndone", done_q.size(), 1);
    check_eq("t4_done_cyc", qget(done_q, 0), t + 37);
    check_eq("t4_nintr", intr_rise_q.size(), 1);
    check_eq("t4_intr_cyc", qget(intr_rise_q, 0), t + 37);

    // four rounds per cycle
    prep();
    start_batch4(1, t);
    step(10);
    for (int i = 0; i < 24; i += 4) exp_q.push_back(i);
    check_seq("t5_round_idx", rnd4_q);
    check_eq("t5_done_cyc", qget(done4_q, 0), t + 7);

    // batch size above MAX_PERM saturates to 16 permutations
    prep();
    start_batch4(31, t);
    step(120);
    check_eq("t5_sat_nstart", start4_q.size(), 16);
    check_eq("t5_sat_ndone", done4_q.size(), 1);
    check_eq("t5_sat_done_cyc", qget(done4_q, 0), t + 112);

    // nperm_i = 0 acts as 1; clear collides with FINISH, then clears later
    prep();
    start_batch(0, t);
    step(24);
    bus.intr_clr_i = 1'b1;
    @(negedge clk);
    #1;
    check_eq("t6_intr_set_wins", bus.intr_o, 1);
    @(negedge clk);
    bus.intr_clr_i = 1'b0;
    #1;
    check_eq("t6_intr_cleared", bus.intr_o, 0);
    check_eq("t6_nstart", start_q.size(), 1);
    check_eq("t6_done_cyc", qget(done_q, 0), t + 25);

    // reset in the middle of a batch
    prep();
    start_batch(2, t);
    step(5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("t7_busy_after_rst", bus.busy_o, 0);
    check_eq("t7_state_after_rst", bus.dbg_state_o, IDLE);
    step(60);
    check_eq("t7_ndone", done_q.size(), 0);
    check_eq("t7_nintr", intr_rise_q.size(), 0);
    check_eq("t7_nstart", start_q.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
